// File: rtl/fb_rect_fill_if.sv
// ---------------------------------------------------------------------------
// fb_rect_fill_if
//   Command and framebuffer-write bundle for the rectangle fill engine.
//   master : command producer / framebuffer observer
//   slave  : fill engine (fb_rect_fill)
//   Signals:
//     cmd_valid, cmd_ready          command handshake
//     cmd_x, cmd_y, cmd_w, cmd_h    rectangle origin and size
//     cmd_color                     fill colour {R,G,B}
//     fb_adr_w, fb_d, fb_we         framebuffer write port
//     busy, done                    engine status
// ---------------------------------------------------------------------------
interface fb_rect_fill_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 24
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [8:0]        cmd_x;
    logic [7:0]        cmd_y;
    logic [8:0]        cmd_w;
    logic [7:0]        cmd_h;
    logic [DATA_W-1:0] cmd_color;
    logic [ADDR_W-1:0] fb_adr_w;
    logic [DATA_W-1:0] fb_d;
    logic              fb_we;
    logic              busy;
    logic              done;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        input  cmd_ready, fb_adr_w, fb_d, fb_we, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        output cmd_ready, fb_adr_w, fb_d, fb_we, busy, done
    );
endinterface

// File: rtl/fb_rect_fill.sv
// ---------------------------------------------------------------------------
// fb_rect_fill
//   Solid-rectangle fill engine. Accepts one rectangle command per handshake,
//   clips it to the H_RES x V_RES framebuffer and writes one pixel per clock,
//   row-major, through the framebuffer write port.
//   Ports:
//     CLOCK_50  system clock, all logic on the rising edge
//     reset     synchronous, active-low
//     bus       fb_rect_fill_if.slave: command handshake in, pixel writes and
//               busy/done status out
// ---------------------------------------------------------------------------
module fb_rect_fill #(
    parameter int H_RES  = 280,   // row pitch; the row_base shift-add below is built for 280
    parameter int V_RES  = 192,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 24
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    fb_rect_fill_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

    state_t            state, state_next;

    logic [8:0]        x_q, x_d;
    logic [7:0]        y_q, y_d;
    logic [8:0]        w_q, w_d;
    logic [7:0]        h_q, h_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic [9:0]        x_end_q, x_end_d;
    logic [9:0]        y_end_q, y_end_d;
    logic [8:0]        col_q, col_d;
    logic [7:0]        row_q, row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] pix_q, pix_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Setup-time arithmetic on the latched command (10-bit so x+w, y+h never wrap).
    logic [9:0]        x_sum, y_sum, x_end_calc, y_end_calc;
    logic              empty;
    logic [ADDR_W-1:0] y_ext, x_ext, base_calc;
    logic              col_last, row_last;
    logic              accept;

    assign x_sum      = {1'b0, x_q} + {1'b0, w_q};
    assign y_sum      = {2'b0, y_q} + {2'b0, h_q};
    assign x_end_calc = (x_sum > 10'(H_RES)) ? 10'(H_RES) : x_sum;
    assign y_end_calc = (y_sum > 10'(V_RES)) ? 10'(V_RES) : y_sum;
    assign empty      = ({1'b0, x_q} >= 10'(H_RES)) || ({2'b0, y_q} >= 10'(V_RES)) ||
                        (w_q == '0) || (h_q == '0);

    // y*280 = y*256 + y*16 + y*8, kept as adders so no multiplier is inferred.
    assign y_ext      = ADDR_W'(y_q);
    assign x_ext      = ADDR_W'(x_q);
    assign base_calc  = (y_ext << 8) + (y_ext << 4) + (y_ext << 3);

    assign col_last   = ({1'b0, col_q} + 10'd1) == x_end_q;
    assign row_last   = ({2'b0, row_q} + 10'd1) == y_end_q;

    // Combinational so the engine is never seen as ready while reset is held.
    assign bus.cmd_ready = (state == IDLE) && reset;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    always_comb begin
        // NOTE: every signal driven here gets its hold value first; a path that
        // left one unassigned would infer a latch.
        state_next = state;
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        h_d        = h_q;
        color_d    = color_q;
        x_end_d    = x_end_q;
        y_end_d    = y_end_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        adr_d      = adr_q;
        pix_d      = pix_q;
        we_d       = we_q;
        done_d     = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    x_d        = bus.cmd_x;
                    y_d        = bus.cmd_y;
                    w_d        = bus.cmd_w;
                    h_d        = bus.cmd_h;
                    color_d    = bus.cmd_color;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                x_end_d = x_end_calc;
                y_end_d = y_end_calc;
                if (empty) begin
                    done_d     = 1'b1;
                    state_next = DONE;
                end else begin
                    row_base_d = base_calc;
                    col_d      = x_q;
                    row_d      = y_q;
                    adr_d      = base_calc + x_ext;
                    pix_d      = color_q;
                    we_d       = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                if (col_last && row_last) begin
                    we_d       = 1'b0;
                    done_d     = 1'b1;
                    state_next = DONE;
                end else if (col_last) begin
                    col_d      = x_q;
                    row_d      = row_q + 8'd1;
                    row_base_d = row_base_q + ADDR_W'(H_RES);
                    adr_d      = row_base_q + ADDR_W'(H_RES) + x_ext;
                end else begin
                    col_d      = col_q + 9'd1;
                    adr_d      = adr_q + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                we_d       = 1'b0;
                state_next = IDLE;
            end
        endcase

        busy_d = (state_next != IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (!reset) begin
            state      <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            color_q    <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            adr_q      <= '0;
            pix_q      <= '0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_next;
            x_q        <= x_d;
            y_q        <= y_d;
            w_q        <= w_d;
            h_q        <= h_d;
            color_q    <= color_d;
            x_end_q    <= x_end_d;
            y_end_q    <= y_end_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            adr_q      <= adr_d;
            pix_q      <= pix_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.fb_adr_w = adr_q;
    assign bus.fb_d     = pix_q;
    assign bus.fb_we    = we_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// ---------------------------------------------------------------------------
// tb_fb_rect_fill
//   Self-checking bench for fb_rect_fill. A reference model expands each
//   rectangle into its list of clipped pixel addresses (y*280+x) and the bench
//   compares the engine's per-cycle outputs against the expected trace:
//   one SETUP cycle, the writes, one DONE cycle, then IDLE.
// ---------------------------------------------------------------------------
module tb_fb_rect_fill;

    localparam int H = 280;
    localparam int V = 192;

    logic CLOCK_50 = 1'b0;
    logic reset;

    always #5 CLOCK_50 = ~CLOCK_50;

    fb_rect_fill_if #(.ADDR_W(16), .DATA_W(24)) bus ();

    fb_rect_fill #(.H_RES(H), .V_RES(V), .ADDR_W(16), .DATA_W(24)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [15:0] last_adr;
    int unsigned exp_q[$];

    // Second command for the back-to-back test, driven mid-fill of the first.
    logic [8:0]  b_x, b_w;
    logic [7:0]  b_y, b_h;
    logic [23:0] b_c;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: every visible pixel of the rectangle, row-major.
    task automatic build_model(input int x, input int y, input int w, input int h);
        exp_q.delete();
        for (int yy = y; yy < y + h; yy++)
            if (yy < V)
                for (int xx = x; xx < x + w; xx++)
                    if (xx < H)
                        exp_q.push_back(yy * H + xx);
    endtask

    function automatic logic [63:0] snap();
        return {16'b0, bus.fb_we, bus.done, bus.busy, bus.cmd_ready, 4'b0,
                bus.fb_adr_w, bus.fb_we ? bus.fb_d : 24'h0};
    endfunction

    function automatic logic [63:0] want(input bit we, input bit dn, input bit bz, input bit rd,
                                         input logic [15:0] adr, input logic [23:0] d);
        return {16'b0, we, dn, bz, rd, 4'b0, adr, we ? d : 24'h0};
    endfunction

    task automatic drive_fields(input int x, input int y, input int w, input int h, input logic [23:0] c);
        bus.cmd_x     = 9'(x);
        bus.cmd_y     = 8'(y);
        bus.cmd_w     = 9'(w);
        bus.cmd_h     = 8'(h);
        bus.cmd_color = c;
    endtask

    task automatic wait_ready(input string tag);
        int i = 0;
        while (bus.cmd_ready !== 1'b1 && i < 100) begin
            @(negedge CLOCK_50);
            i++;
        end
        if (i >= 100) check({tag, "_ready_timeout"}, {63'b0, bus.cmd_ready}, 64'd1);
    endtask

    // Present a command, complete the handshake, then drop cmd_valid.
    task automatic issue(input string tag, input int x, input int y, input int w, input int h,
                         input logic [23:0] c);
        @(negedge CLOCK_50);
        drive_fields(x, y, w, h, c);
        bus.cmd_valid = 1'b1;
        wait_ready(tag);
        @(posedge CLOCK_50);
        #1 bus.cmd_valid = 1'b0;
        build_model(x, y, w, h);
    endtask

    // Check cycle k after the handshake edge: k=0 SETUP, 1..n writes,
    // n+1 DONE, n+2 back in IDLE. Stops early after max_k.
    task automatic trace(input string tag, input logic [23:0] c, input int max_k, input bit garble);
        int          n  = exp_q.size();
        bit          ok = 1'b1;
        int unsigned a;
        logic [63:0] e;
        for (int k = 0; k <= n + 2 && k <= max_k; k++) begin
            @(negedge CLOCK_50);
            if (garble) begin
                if (k >= 5) drive_fields(b_x, b_y, b_w, b_h, b_c);
                else drive_fields($urandom_range(0, 511), $urandom_range(0, 255),
                                  $urandom_range(0, 511), $urandom_range(0, 255), 24'($urandom));
            end
            if (k == 0) e = want(1'b0, 1'b0, 1'b1, 1'b0, last_adr, 24'h0);
            else if (k <= n) begin
                a = exp_q[k-1];
                e = want(1'b1, 1'b0, 1'b1, 1'b0, a[15:0], c);
            end
            else if (k == n + 1) e = want(1'b0, 1'b1, 1'b1, 1'b0, last_adr, 24'h0);
            else e = want(1'b0, 1'b0, 1'b0, 1'b1, last_adr, 24'h0);
            ok = (snap() === e);
            check($sformatf("%s_k%0d", tag, k), snap(), e);
            if (k >= 1 && k <= n) last_adr = e[39:24];
            if (!ok) break;
        end
        if (!ok) begin
            int i = 0;
            while (bus.cmd_ready !== 1'b1 && i < 70000) begin
                @(negedge CLOCK_50);
                i++;
            end
            if (i >= 70000) check({tag, "_resync_timeout"}, {63'b0, bus.cmd_ready}, 64'd1);
        end
    endtask

    task automatic run(input string tag, input int x, input int y, input int w, input int h,
                       input logic [23:0] c);
        issue(tag, x, y, w, h, c);
        trace(tag, c, 1 << 30, 1'b0);
    endtask

    initial begin
        reset         = 1'b0;
        bus.cmd_valid = 1'b0;
        drive_fields(0, 0, 0, 0, 24'h0);
        last_adr      = 16'h0;

        // Reset state.
        repeat (3) @(negedge CLOCK_50);
        check("reset_outputs", snap(), want(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 24'h0));
        check("reset_fb_d", {40'b0, bus.fb_d}, 64'h0);
        reset = 1'b1;
        #1 check("ready_after_reset", {63'b0, bus.cmd_ready}, 64'd1);

        // Small 2x2 at origin.
        run("t1_2x2", 0, 0, 2, 2, 24'hFF0000);

        // Clipped at the bottom-right corner: only 53758, 53759.
        run("t2_clip", 278, 191, 5, 3, 24'h00FF00);

        // Empty commands.
        run("t3_w0", 10, 10, 0, 5, 24'h123456);
        run("t3_x300", 300, 10, 5, 5, 24'h654321);
        run("t3_h0", 0, 0, 4, 0, 24'hABCDEF);
        run("t3_y200", 0, 200, 4, 4, 24'h0000FF);

        // Full screen.
        run("t4_full", 0, 0, H, V, 24'h5A5A5A);

        // Back-to-back with cmd_valid held and fields toggled mid-fill.
        b_x = 9'd100; b_y = 8'd50; b_w = 9'd3; b_h = 8'd2; b_c = 24'h00AA55;
        @(negedge CLOCK_50);
        drive_fields(20, 30, 10, 10, 24'hC0FFEE);
        bus.cmd_valid = 1'b1;
        wait_ready("t5a");
        @(posedge CLOCK_50);
        build_model(20, 30, 10, 10);
        trace("t5a", 24'hC0FFEE, 1 << 30, 1'b1);
        @(posedge CLOCK_50);
        #1 bus.cmd_valid = 1'b0;
        build_model(100, 50, 3, 2);
        trace("t5b", 24'h00AA55, 1 << 30, 1'b0);

        // Reset pulse during a 10x10 fill, then a fresh command.
        issue("t6_pre", 5, 5, 10, 10, 24'h777777);
        trace("t6_pre", 24'h777777, 15, 1'b0);
        reset = 1'b0;
        @(negedge CLOCK_50);
        check("t6_reset_outputs", snap(), want(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 24'h0));
        last_adr = 16'h0;
        reset = 1'b1;
        #1 check("t6_ready_after_reset", {63'b0, bus.cmd_ready}, 64'd1);
        run("t6_post", 270, 185, 20, 20, 24'h13579B);

        // Random rectangles, including off-screen and empty ones.
        for (int i = 0; i < 24; i++) begin
            int rx = $urandom_range(0, 290);
            int ry = $urandom_range(0, 200);
            int rw = $urandom_range(0, 24);
            int rh = $urandom_range(0, 12);
            run($sformatf("rand%0d", i), rx, ry, rw, rh, 24'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
